ucc_chain_ctrl: RTL
===================

Name: ucc_chain_ctrl

Overview:
- Host-side controller for a cascade of universal counter slices sharing one 8-bit bidirectional data bus.
- Accepts commands through a valid/ready handshake and turns each one into a timed sequence on the chain:
  - slice mode code
  - carry-in
  - bus drive/release
- Issues bus writes (parallel load) and bus reads (readback), and runs up-counts and down-counts for a programmed number of cycles.
- Sits between a CPU-side register block and the counter chain.

Parameters:
- W, 8, data bus width; equals slice width.
- LEN_W, 16, width of the run-length field for count commands.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  operation: 0 READ, 1 LOAD, 2 UP, 3 DOWN.
- cmd_data  in  W  load value (LOAD only).
- cmd_len  in  LEN_W  number of count cycles (UP/DOWN only).
- rsp_valid  out  1  one-cycle pulse: command complete.
- rsp_data  out  W  value sampled from bus (valid with rsp_valid after READ; holds otherwise).
- rsp_tc  out  1  terminal carry seen during the last UP run.
- chain_mode  out  2  mode code to first slice: 0 hold, 1 count up, 2 count down, 3 load from bus.
- chain_cin  out  1  carry-in to first slice.
- chain_tc  in  1  carry-out of last slice.
- bus  inout  W  shared slice data bus; driven only while bus_oe is 1, otherwise high-Z.

Behaviour:
- Reset (rst=0 at clk edge):
  - State IDLE.
  - chain_mode=0, chain_cin=0, bus_oe=0 (bus high-Z).
  - cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_tc=0.
  - Reset mid-command aborts immediately; no response is issued.
- All chain outputs and bus_oe are registered; no combinational path from cmd_* to chain_*.
- Handshake:
  - A command is accepted on an edge where cmd_valid=1 and cmd_ready=1.
  - cmd_ready=1 only in IDLE; it drops the cycle after acceptance.
  - Operands are latched at acceptance.
- States: IDLE, LOAD, TURN, SETTLE, SAMPLE, RUN, DONE.
- LOAD: IDLE -> LOAD (1 cycle) -> TURN -> DONE.
  - LOAD cycle: chain_mode=3, bus_oe=1, bus=cmd_data. Slices capture at the edge ending this cycle.
  - TURN cycle: chain_mode=0, bus_oe=0. This is the one-cycle bus turnaround.
- READ: IDLE -> SETTLE -> SAMPLE -> DONE.
  - chain_mode=0 and bus_oe=0 throughout.
  - rsp_data captures bus at the edge ending SAMPLE.
- UP/DOWN: IDLE -> RUN for exactly cmd_len cycles -> DONE.
  - chain_mode is 1 (UP) or 2 (DOWN); chain_cin=1 for UP, 0 for DOWN; bus_oe=0.
  - cmd_len=0: go directly to DONE and issue no count cycle.
  - RUN uses an internal LEN_W down-counter.
- Terminal carry (UP only):
  - rsp_tc is cleared at acceptance of any UP command.
  - rsp_tc is set if chain_tc=1 is sampled on any RUN edge; it stays sticky until the next UP.
  - DOWN, READ and LOAD leave rsp_tc unchanged.
- DONE: chain_mode=0, chain_cin=0, rsp_valid=1 for one cycle, then IDLE (cmd_ready=1 the following cycle).
- Latency from acceptance edge to rsp_valid: LOAD 3, READ 3, UP/DOWN cmd_len+1 cycles.
- Bus contention rule: bus_oe=1 only while chain_mode=3. Guaranteed by construction; the bench asserts it.

Decomposition:
- Shared package ucc_pkg:
  - enum op_t (READ/LOAD/UP/DOWN)
  - enum mode_t (HOLD=0, UP=1, DOWN=2, LOAD=3)
  - state enum
  - W default
- Slice testbenches reuse mode_t from ucc_pkg.
- One sub-module: ucc_len_counter, a loadable LEN_W down-counter with zero flag, used by RUN.
- Tri-state bus driver stays inline.

Test Plan:
- Reset: hold rst=0 for 2 cycles during an UP run of len 100 -> chain_mode=0, bus high-Z, cmd_ready=1, no rsp_valid.
- LOAD 8'hA5:
  - Exactly one cycle has chain_mode=3 with bus=8'hA5.
  - The next cycle has bus=Z.
  - rsp_valid 3 cycles after acceptance.
  - A following READ returns rsp_data=8'hA5 with a slice model attached.
- LOAD 8'hFE then UP len 3:
  - Exactly 3 cycles of chain_mode=1, chain_cin=1.
  - Slice model wraps, so rsp_tc=1.
  - READ returns 8'h01.
- LOAD 8'h05 then DOWN len 5: READ returns 8'h00, rsp_tc unchanged.
- UP len 0: rsp_valid on the next cycle after acceptance, no count cycles issued.
- Back-to-back: cmd_valid held high with 4 queued commands -> each accepted only when cmd_ready=1, no overlap, bus_oe never 1 with chain_mode!=3.

Source files
------------

// File: rtl/ucc_pkg.sv
// Shared types and constants for the universal counter chain controller and slice benches.
package ucc_pkg;

    localparam int UCC_W = 8;

    // Host command opcodes
    typedef enum logic [1:0] {
        OP_READ = 2'd0,
        OP_LOAD = 2'd1,
        OP_UP   = 2'd2,
        OP_DOWN = 2'd3
    } op_t;

    // Mode codes understood by every counter slice
    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_UP   = 2'd1,
        MODE_DOWN = 2'd2,
        MODE_LOAD = 2'd3
    } mode_t;

    // Controller states
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_TURN   = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_SAMPLE = 3'd4;
    localparam logic [2:0] ST_RUN    = 3'd5;
    localparam logic [2:0] ST_DONE   = 3'd6;

endpackage

// File: rtl/ucc_len_counter.sv
// Loadable down-counter with a zero flag; times the RUN phase of count commands.
module ucc_len_counter #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [LEN_W-1:0] count_reg;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - LEN_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/ucc_chain_ctrl.sv
// Host-side sequencer for a cascade of counter slices on a shared tri-state data bus.
module ucc_chain_ctrl
    import ucc_pkg::*;
#(
    parameter int W     = UCC_W,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [W-1:0]     cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             rsp_valid,
    output logic [W-1:0]     rsp_data,
    output logic             rsp_tc,
    output logic [1:0]       chain_mode,
    output logic             chain_cin,
    input  logic             chain_tc,
    inout  wire  [W-1:0]     bus
);

    logic [2:0]   state_reg, state_next;
    op_t          op_reg;
    logic [W-1:0] data_reg;
    mode_t        mode_reg, mode_next;
    logic         cin_reg, cin_next;
    logic         oe_reg, oe_next;
    logic         ready_reg;
    logic         rsp_valid_reg;
    logic [W-1:0] rsp_data_reg;
    logic         rsp_tc_reg;
    logic         accept;
    logic         run_up;
    logic         len_zero;

    assign accept = cmd_valid && ready_reg;

    // While accepting, the direction comes from the incoming opcode; afterwards from the latched one.
    assign run_up = (state_reg == ST_IDLE) ? (cmd_op == OP_UP) : (op_reg == OP_UP);

    // The counter is loaded with len-1 so that RUN ends on the cycle it reads zero.
    ucc_len_counter #(.LEN_W(LEN_W)) u_len (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_value (cmd_len - LEN_W'(1)),
        .dec        (state_reg == ST_RUN),
        .zero       (len_zero)
    );

    // Next-state sequencing for all command types.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_READ: state_next = ST_SETTLE;
                        OP_LOAD: state_next = ST_LOAD;
                        default: state_next = (cmd_len == '0) ? ST_DONE : ST_RUN;
                    endcase
                end
            end
            ST_LOAD:   state_next = ST_TURN;
            ST_TURN:   state_next = ST_DONE;
            ST_SETTLE: state_next = ST_SAMPLE;
            ST_SAMPLE: state_next = ST_DONE;
            ST_RUN:    state_next = len_zero ? ST_DONE : ST_RUN;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Chain outputs are decoded from the next state so they register in step with it.
    always_comb begin
        mode_next = MODE_HOLD;
        cin_next  = 1'b0;
        oe_next   = 1'b0;
        case (state_next)
            ST_LOAD: begin
                mode_next = MODE_LOAD;
                oe_next   = 1'b1;
            end
            ST_RUN: begin
                mode_next = run_up ? MODE_UP : MODE_DOWN;
                cin_next  = run_up;
            end
            default: ;
        endcase
    end

    // State, chain drive, operand latches and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_READ;
            data_reg      <= '0;
            mode_reg      <= MODE_HOLD;
            cin_reg       <= 1'b0;
            oe_reg        <= 1'b0;
            ready_reg     <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_tc_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mode_reg      <= mode_next;
            cin_reg       <= cin_next;
            oe_reg        <= oe_next;
            ready_reg     <= (state_next == ST_IDLE);
            rsp_valid_reg <= (state_next == ST_DONE);
            if (accept) begin
                op_reg   <= op_t'(cmd_op);
                data_reg <= cmd_data;
            end
            if (state_reg == ST_SAMPLE) begin
                rsp_data_reg <= bus;
            end
            if (accept && (cmd_op == OP_UP)) begin
                rsp_tc_reg <= 1'b0;
            end else if ((state_reg == ST_RUN) && (op_reg == OP_UP) && chain_tc) begin
                rsp_tc_reg <= 1'b1;
            end
        end
    end

    assign bus        = oe_reg ? data_reg : {W{1'bz}};
    assign cmd_ready  = ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_data   = rsp_data_reg;
    assign rsp_tc     = rsp_tc_reg;
    assign chain_mode = mode_reg;
    assign chain_cin  = cin_reg;

endmodule
